seven_seg_editor: RTL and testbench
===================================

Name: seven_seg_editor

Overview:
- Parametrised multi-digit 7-segment editor for the FPGA test boards; successor to the single-digit button/segment test logic.
- Four raw push-buttons are synchronised, debounced and turned into one-cycle press pulses that edit a NUM_DIGITS-wide BCD value and move a cursor.
- Time-multiplexed scan drives all digits; the digit under the cursor blinks.
- A parallel load port lets a host preset the value.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz/digit at 50 MHz)
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles to accept a button level change (10 ms)
- BLINK_DIV, 12500000, clk cycles per blink half-period
- MAX_VALUE, 9, largest legal digit value (1..15)
- WRAP, 0, 0 = saturate at 0/MAX_VALUE; 1 = wrap MAX_VALUE<->0 (no carry to neighbour)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- btn_inc  in  1  raw button, 0 = pushed; increments digit under cursor
- btn_dec  in  1  raw button, 0 = pushed; decrements digit under cursor
- btn_left  in  1  raw button, 0 = pushed; cursor toward MSD (index+1)
- btn_right  in  1  raw button, 0 = pushed; cursor toward LSD (index-1)
- load  in  1  synchronous preset strobe
- load_value  in  4*NUM_DIGITS  preset value, digit i in bits [4i+3:4i]
- seg  out  8  segments, active-low, bit7 = dp (always 1)
- dig  out  NUM_DIGITS  digit select, active-low one-cold, bit0 = rightmost
- value  out  4*NUM_DIGITS  current edited value
- cursor  out  clog2(NUM_DIGITS)  cursor digit index
- heartbeat  out  1  blink phase, toggles every BLINK_DIV cycles

Behaviour:
- Reset (async assert, sync release): value=0, cursor=0, scan index=0, seg=8'hFF, dig=all ones, heartbeat=0. Debounced states = 1 (released), all counters 0, no pulses.
- Per button: 2-FF synchroniser, then debounce counter.
  - Counter clears whenever the synced level equals the stable state.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the stable state takes the synced level and the counter clears.
  - Press pulse is 1 cycle, registered, on stable 1->0 only; release produces no pulse.
  - Latency: raw low held from cycle 0 gives the pulse at cycle DEBOUNCE_CYCLES+2; the value/cursor update is visible one cycle later.
- Edit priority, per cycle:
  - load > inc/dec.
  - inc and dec pulses in the same cycle: no change.
  - left and right pulses in the same cycle: no cursor change.
  - Digit and cursor edits in the same cycle are both applied; the digit edit uses the old cursor.
- Digit arithmetic: 4-bit.
  - inc at MAX_VALUE gives MAX_VALUE (WRAP=0) or 0 (WRAP=1).
  - dec at 0 gives 0 (WRAP=0) or MAX_VALUE (WRAP=1).
- Load: each nibble greater than MAX_VALUE is clamped to MAX_VALUE. Cursor is unchanged.
- Cursor saturates at 0 and NUM_DIGITS-1 (never wraps).
- Scan:
  - Divider counts 0..SCAN_DIV-1; at terminal count the scan index advances, wrapping NUM_DIGITS-1 -> 0.
  - seg and dig are registered together from the current index: dig has bit[index]=0, others 1.
  - Decode table (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=D8, 8=80, 9=90; any value >9 gives 89.
  - Blanking: seg=FF when index==cursor and heartbeat==1.
- Blink: divider 0..BLINK_DIV-1; heartbeat toggles at terminal count. The divider is free-running and is not restarted by edits.
- Reset mid-debounce or mid-scan: all state returns to reset values immediately. No pulse is emitted for a button still held after reset until it has been released and pressed again.

Test Plan (sim params: NUM_DIGITS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8, BLINK_DIV=16):
- Reset then idle 64 cycles -> dig cycles 1110, 1101, 1011, 0111, each held 4 cycles. seg=C0 on all digits except cursor digit 0, which reads FF while heartbeat=1. value=0x0000.
- btn_inc low 20 cycles, glitch-free -> exactly one pulse at cycle 10, value=0x0001 at cycle 11. Repeat 10 presses with WRAP=0 -> value=0x0009. Same test with WRAP=1 -> value=0x0000.
- btn_inc bouncing (low 3 cycles, high 1 cycle, repeated) -> no pulse, value unchanged. Then held low 8+ cycles -> single increment.
- btn_left pressed 5 times -> cursor 1, 2, 3, 3, 3. btn_inc -> value=0x1000. btn_right at cursor 0 -> cursor stays 0.
- load with load_value=0xFA37 -> value=0x9937 next cycle. load coincident with an inc pulse -> load wins, value=0x9937.
- Simultaneous inc+dec pulses -> value unchanged. Assert rstn=0 during scan index 2 and a half-debounced press -> all outputs back to reset values and no pulse after release of reset.

Source files
------------

// File: rtl/seven_seg_editor.sv
// Multi-digit BCD editor: debounced buttons edit a value under a cursor,
// and a time-multiplexed scan drives the segments with a blinking cursor.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   btn_inc/dec/left/right     raw buttons, 0 = pushed
//   load, load_value           synchronous preset (nibbles clamped)
//   seg                        active-low segments, bit7 = dp (kept off)
//   dig                        active-low one-cold digit select
//   value, cursor              current edited value and cursor index
//   heartbeat                  blink phase
module seven_seg_editor #(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 12500000,
  parameter int MAX_VALUE       = 9,
  parameter int WRAP            = 0
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            btn_inc,
  input  logic                            btn_dec,
  input  logic                            btn_left,
  input  logic                            btn_right,
  input  logic                            load,
  input  logic [4*NUM_DIGITS-1:0]         load_value,
  output logic [7:0]                      seg,
  output logic [NUM_DIGITS-1:0]           dig,
  output logic [4*NUM_DIGITS-1:0]         value,
  output logic [$clog2(NUM_DIGITS)-1:0]   cursor,
  output logic                            heartbeat
);

  localparam int CW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [3:0]    MAXV    = 4'(MAX_VALUE);
  localparam logic [CW-1:0] CUR_TOP = CW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DEB_TOP = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCN_TOP = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_TOP = BW'(BLINK_DIV - 1);

  // Button order: 0 inc, 1 dec, 2 left, 3 right
  logic [3:0]    raw;
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    stable_q;
  logic [3:0]    armed_q;
  logic [3:0]    pulse_q;
  logic [DW-1:0] deb_q [4];

  assign raw = {btn_right, btn_left, btn_dec, btn_inc};

  // Synchronisers reset to "pushed" and a press is only armed once a
  // released level has been seen, so a button held through reset
  // produces no pulse until it is released and pressed again.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '1;
      armed_q  <= '0;
      pulse_q  <= '0;
      for (int b = 0; b < 4; b++) deb_q[b] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      armed_q <= armed_q | sync2_q;
      for (int b = 0; b < 4; b++) begin
        pulse_q[b] <= 1'b0;
        if (sync2_q[b] == stable_q[b]) begin
          deb_q[b] <= '0;
        end else if (deb_q[b] == DEB_TOP) begin
          deb_q[b]    <= '0;
          stable_q[b] <= sync2_q[b];
          pulse_q[b]  <= stable_q[b] & armed_q[b];
        end else begin
          deb_q[b] <= deb_q[b] + 1'b1;
        end
      end
    end
  end

  logic          inc_p, dec_p, left_p, right_p;
  logic [VW-1:0] value_q, value_d;
  logic [CW-1:0] cursor_q, cursor_d;
  logic [3:0]    cur_dig;
  logic [3:0]    ld_nib;

  assign inc_p   = pulse_q[0];
  assign dec_p   = pulse_q[1];
  assign left_p  = pulse_q[2];
  assign right_p = pulse_q[3];
  assign cur_dig = value_q[4*int'(cursor_q) +: 4];

  always_comb begin
    value_d  = value_q;
    cursor_d = cursor_q;
    ld_nib   = '0;
    if (load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        ld_nib = load_value[4*i +: 4];
        value_d[4*i +: 4] = (ld_nib > MAXV) ? MAXV : ld_nib;
      end
    end else if (inc_p && !dec_p) begin
      if (cur_dig >= MAXV)
        value_d[4*int'(cursor_q) +: 4] = (WRAP != 0) ? 4'd0 : MAXV;
      else
        value_d[4*int'(cursor_q) +: 4] = cur_dig + 4'd1;
    end else if (dec_p && !inc_p) begin
      if (cur_dig == 4'd0)
        value_d[4*int'(cursor_q) +: 4] = (WRAP != 0) ? MAXV : 4'd0;
      else
        value_d[4*int'(cursor_q) +: 4] = cur_dig - 4'd1;
    end
    // Cursor edits use the same old cursor as the digit edit above.
    if (left_p && !right_p) begin
      if (cursor_q != CUR_TOP) cursor_d = cursor_q + 1'b1;
    end else if (right_p && !left_p) begin
      if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value_q  <= '0;
      cursor_q <= '0;
    end else begin
      value_q  <= value_d;
      cursor_q <= cursor_d;
    end
  end

  logic [BW-1:0] blk_q;
  logic          hb_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_q <= '0;
      hb_q  <= 1'b0;
    end else if (blk_q == BLK_TOP) begin
      blk_q <= '0;
      hb_q  <= ~hb_q;
    end else begin
      blk_q <= blk_q + 1'b1;
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hD8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = 8'h89;
    endcase
  endfunction

  logic [SW-1:0]         scn_q;
  logic [CW-1:0]         idx_q;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  always_comb begin
    dig_d = ~(NUM_DIGITS'(1) << idx_q);
    if (idx_q == cursor_q && hb_q)
      seg_d = 8'hFF;
    else
      seg_d = seg_of(value_q[4*int'(idx_q) +: 4]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scn_q <= '0;
      idx_q <= '0;
      seg_q <= 8'hFF;
      dig_q <= '1;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      if (scn_q == SCN_TOP) begin
        scn_q <= '0;
        idx_q <= (idx_q == CUR_TOP) ? '0 : idx_q + 1'b1;
      end else begin
        scn_q <= scn_q + 1'b1;
      end
    end
  end

  assign seg       = seg_q;
  assign dig       = dig_q;
  assign value     = value_q;
  assign cursor    = cursor_q;
  assign heartbeat = hb_q;

endmodule

// File: tb/tb_seven_seg_editor.sv
// Self-checking bench for seven_seg_editor: a saturating and a wrapping
// instance share stimulus; expected values queue up and are popped on output.
module tb_seven_seg_editor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  btn_n;
  logic        load;
  logic [15:0] load_value;

  logic [7:0]  seg, seg_w;
  logic [3:0]  dig, dig_w;
  logic [15:0] value, value_w;
  logic [1:0]  cursor, cursor_w;
  logic        hb, hb_w;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] vq[$];
  logic [15:0] wq[$];
  logic [1:0]  cq[$];
  logic [12:0] sq[$];

  always #5 clk = ~clk;

  seven_seg_editor #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
    .BLINK_DIV(16), .MAX_VALUE(9), .WRAP(0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .btn_inc(btn_n[0]), .btn_dec(btn_n[1]),
    .btn_left(btn_n[2]), .btn_right(btn_n[3]),
    .load(load), .load_value(load_value),
    .seg(seg), .dig(dig), .value(value),
    .cursor(cursor), .heartbeat(hb)
  );

  seven_seg_editor #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
    .BLINK_DIV(16), .MAX_VALUE(9), .WRAP(1)
  ) dutw (
    .clk(clk), .rstn(rstn),
    .btn_inc(btn_n[0]), .btn_dec(btn_n[1]),
    .btn_left(btn_n[2]), .btn_right(btn_n[3]),
    .load(load), .load_value(load_value),
    .seg(seg_w), .dig(dig_w), .value(value_w),
    .cursor(cursor_w), .heartbeat(hb_w)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given buttons low long enough for one press, then let the
  // release settle so the next press starts from idle.
  task automatic press(input logic [3:0] mask);
    btn_n = ~mask;
    tick(20);
    btn_n = 4'hF;
    tick(14);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] e;
    rstn = 1'b0;
    btn_n = 4'hF;
    load = 1'b0;
    load_value = '0;
    tick(3);
    n_cmp++;
    if ({seg, dig, hb, cursor} !== {8'hFF, 4'hF, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL reset_out got seg=%h dig=%b hb=%b cur=%0d",
               seg, dig, hb, cursor);
    end
    vq.push_back(16'h0000);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL reset_value got %h exp %h", value, e);
    end
    n_cmp++;
    if ({seg_w, dig_w, hb_w, cursor_w, value_w} !==
        {8'hFF, 4'hF, 1'b0, 2'd0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_wrap got seg=%h dig=%b v=%h",
               seg_w, dig_w, value_w);
    end
    rstn = 1'b1;
  endtask

  task automatic test_scan;
    int idx, ph;
    logic [12:0] e;
    for (int k = 1; k <= 64; k++) begin
      idx = ((k - 1) / 4) % 4;
      ph  = ((k - 1) / 16) % 2;
      e[12]   = 1'((k / 16) % 2);
      e[11:8] = ~(4'b0001 << idx);
      e[7:0]  = (idx == 0 && ph == 1) ? 8'hFF : 8'hC0;
      sq.push_back(e);
      tick(1);
      e = sq.pop_front();
      n_cmp++;
      if ({hb, dig, seg} !== e) begin
        n_err++;
        $display("FAIL scan k=%0d got hb=%b dig=%b seg=%h exp %b %b %h",
                 k, hb, dig, seg, e[12], e[11:8], e[7:0]);
      end
    end
  endtask

  task automatic test_inc;
    logic [15:0] e, ew;
    vq.push_back(16'h0001);
    btn_n[0] = 1'b0;
    tick(10);
    n_cmp++;
    if (value !== 16'h0000) begin
      n_err++;
      $display("FAIL inc_early got %h exp 0000", value);
    end
    tick(1);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL inc_latency got %h exp %h", value, e);
    end
    tick(9);
    btn_n = 4'hF;
    tick(14);
    for (int i = 2; i <= 10; i++) begin
      vq.push_back(16'(i > 9 ? 9 : i));
      wq.push_back(16'(i % 10));
      press(4'b0001);
      e  = vq.pop_front();
      ew = wq.pop_front();
      n_cmp++;
      if (value !== e) begin
        n_err++;
        $display("FAIL inc_sat n=%0d got %h exp %h", i, value, e);
      end
      n_cmp++;
      if (value_w !== ew) begin
        n_err++;
        $display("FAIL inc_wrap n=%0d got %h exp %h", i, value_w, ew);
      end
    end
  endtask

  task automatic test_bounce;
    logic [15:0] e;
    do_load(16'h0003);
    vq.push_back(16'h0003);
    repeat (6) begin
      btn_n[0] = 1'b0;
      tick(3);
      btn_n[0] = 1'b1;
      tick(1);
    end
    tick(14);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL bounce got %h exp %h", value, e);
    end
    vq.push_back(16'h0004);
    btn_n[0] = 1'b0;
    tick(12);
    btn_n[0] = 1'b1;
    tick(14);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL bounce_hold got %h exp %h", value, e);
    end
  endtask

  task automatic test_cursor;
    logic [15:0] e;
    logic [1:0]  c;
    do_load(16'h0000);
    for (int i = 1; i <= 5; i++) begin
      cq.push_back(2'(i > 3 ? 3 : i));
      press(4'b0100);
      c = cq.pop_front();
      n_cmp++;
      if (cursor !== c) begin
        n_err++;
        $display("FAIL left n=%0d got %0d exp %0d", i, cursor, c);
      end
    end
    vq.push_back(16'h1000);
    press(4'b0001);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL inc_msd got %h exp %h", value, e);
    end
    for (int i = 1; i <= 4; i++) begin
      cq.push_back(2'(i > 3 ? 0 : 3 - i));
      press(4'b1000);
      c = cq.pop_front();
      n_cmp++;
      if (cursor !== c) begin
        n_err++;
        $display("FAIL right n=%0d got %0d exp %0d", i, cursor, c);
      end
    end
  endtask

  task automatic test_load;
    logic [15:0] e;
    vq.push_back(16'h9937);
    do_load(16'hFA37);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL load_clamp got %h exp %h", value, e);
    end
    vq.push_back(16'h9937);
    btn_n[0] = 1'b0;
    tick(10);
    load_value = 16'hFA37;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(9);
    btn_n = 4'hF;
    tick(14);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL load_vs_inc got %h exp %h", value, e);
    end
  endtask

  task automatic test_dec_wrap;
    logic [15:0] e, ew;
    do_load(16'h0000);
    vq.push_back(16'h0000);
    wq.push_back(16'h0009);
    press(4'b0010);
    e  = vq.pop_front();
    ew = wq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL dec_sat got %h exp %h", value, e);
    end
    n_cmp++;
    if (value_w !== ew) begin
      n_err++;
      $display("FAIL dec_wrap got %h exp %h", value_w, ew);
    end
  endtask

  task automatic test_simultaneous;
    logic [15:0] e;
    logic [1:0]  c;
    do_load(16'h0005);
    vq.push_back(16'h0005);
    press(4'b0011);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL inc_dec got %h exp %h", value, e);
    end
    cq.push_back(2'd0);
    press(4'b1100);
    c = cq.pop_front();
    n_cmp++;
    if (cursor !== c) begin
      n_err++;
      $display("FAIL left_right got %0d exp %0d", cursor, c);
    end
    vq.push_back(16'h0006);
    cq.push_back(2'd1);
    press(4'b0101);
    e = vq.pop_front();
    c = cq.pop_front();
    n_cmp++;
    if ({value, cursor} !== {e, c}) begin
      n_err++;
      $display("FAIL inc_left got %h/%0d exp %h/%0d", value, cursor, e, c);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] e;
    for (int i = 0; i < 32 && dig !== 4'b1101; i++) tick(1);
    n_cmp++;
    if (dig !== 4'b1101) begin
      n_err++;
      $display("FAIL wait_idx1 got %b exp 1101", dig);
    end
    btn_n[0] = 1'b0;
    for (int i = 0; i < 8 && dig !== 4'b1011; i++) tick(1);
    n_cmp++;
    if (dig !== 4'b1011) begin
      n_err++;
      $display("FAIL wait_idx2 got %b exp 1011", dig);
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({seg, dig, hb, cursor, value} !==
        {8'hFF, 4'hF, 1'b0, 2'd0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_mid got seg=%h dig=%b hb=%b c=%0d v=%h",
               seg, dig, hb, cursor, value);
    end
    btn_n = 4'hF;
    tick(2);
    rstn = 1'b1;
    vq.push_back(16'h0000);
    tick(20);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL reset_no_pulse got %h exp %h", value, e);
    end
    btn_n[0] = 1'b0;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    vq.push_back(16'h0000);
    tick(20);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL held_thru_reset got %h exp %h", value, e);
    end
    btn_n = 4'hF;
    tick(14);
    vq.push_back(16'h0001);
    press(4'b0001);
    e = vq.pop_front();
    n_cmp++;
    if (value !== e) begin
      n_err++;
      $display("FAIL repress got %h exp %h", value, e);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_inc();
    test_bounce();
    test_cursor();
    test_load();
    test_dec_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
